// File: rtl/uart_cmd_parser.sv
// UART command-frame parser: AA 55 CMD LEN payload CHK -> command held for a ready/valid handshake.
// Define UART_CMD_CHKSUM_EN to enforce the CHK byte; otherwise it is consumed without comparison.
module uart_cmd_parser #(
    parameter int UART_CLK_MHZ = 50,
    parameter int MAX_PAYLOAD  = 16,
    parameter int TIMEOUT_US   = 1000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               rx_data_i,
    input  logic                     rx_int_i,
    output logic                     cmd_valid_o,
    input  logic                     cmd_ready_i,
    output logic [7:0]               cmd_id_o,
    output logic [4:0]               cmd_len_o,
    output logic [8*MAX_PAYLOAD-1:0] cmd_payload_o,
    output logic                     frame_err_o,
    output logic [1:0]               err_code_o,
    output logic                     overrun_o,
    output logic                     busy_o
);
    localparam int TIMEOUT_CYCLES = TIMEOUT_US * UART_CLK_MHZ;
    localparam int TW             = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, HDR2, CMD, LEN, PAYLOAD, CHK, HOLD} state_t;

    state_t        state, state_nxt;
    logic          rx_q1, rx_q2, strobe;
    logic [TW-1:0] timer;
    logic [4:0]    idx;
    logic          timer_run, expired, chk_ok, abort;
    logic [1:0]    abort_code;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_q1 <= 1'b0;
            rx_q2 <= 1'b0;
        end else begin
            rx_q1 <= rx_int_i;
            rx_q2 <= rx_q1;
        end
    end

    assign strobe    = rx_q1 & ~rx_q2;
    assign timer_run = state inside {HDR2, CMD, LEN, PAYLOAD, CHK};
    // A strobe landing on the expiry cycle wins, so expiry is masked by it.
    assign expired   = timer_run && !strobe && (timer == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst || strobe || !timer_run || expired) timer <= '0;
        else                                        timer <= timer + TW'(1);
    end

`ifdef UART_CMD_CHKSUM_EN
    logic [7:0] sum;

    always_ff @(posedge clk) begin
        if (rst) begin
            sum <= '0;
        end else if (strobe) begin
            case (state)
                CMD:          sum <= rx_data_i;
                LEN, PAYLOAD: sum <= sum + rx_data_i;
                default:      ;
            endcase
        end
    end

    assign chk_ok = (sum == rx_data_i);
`else
    assign chk_ok = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // NOTE: every variable written here gets a default first so no latch is inferred.
    always_comb begin
        state_nxt  = state;
        abort      = 1'b0;
        abort_code = 2'd0;
        if (expired) begin
            state_nxt  = IDLE;
            abort      = 1'b1;
            abort_code = 2'd3;
        end else if (strobe) begin
            case (state)
                IDLE: if (rx_data_i == 8'hAA) state_nxt = HDR2;
                HDR2: begin
                    if (rx_data_i == 8'h55)      state_nxt = CMD;
                    else if (rx_data_i != 8'hAA) state_nxt = IDLE;
                end
                CMD:  state_nxt = LEN;
                LEN: begin
                    if (rx_data_i > 8'(MAX_PAYLOAD)) begin
                        state_nxt  = IDLE;
                        abort      = 1'b1;
                        abort_code = 2'd1;
                    end else if (rx_data_i == 8'd0) begin
                        state_nxt = CHK;
                    end else begin
                        state_nxt = PAYLOAD;
                    end
                end
                PAYLOAD: if (idx == cmd_len_o - 5'd1) state_nxt = CHK;
                CHK: begin
                    if (chk_ok) begin
                        state_nxt = HOLD;
                    end else begin
                        state_nxt  = IDLE;
                        abort      = 1'b1;
                        abort_code = 2'd2;
                    end
                end
                default: ;
            endcase
        end
        if (state == HOLD && cmd_ready_i) state_nxt = IDLE;
    end

    always_comb begin
        cmd_valid_o = 1'b0;
        busy_o      = 1'b0;
        if (state == HOLD) cmd_valid_o = 1'b1;
        if (state != IDLE) busy_o = 1'b1;
    end

    // NOTE: the payload store is reset explicitly because it drives outputs that must read zero after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_err_o   <= 1'b0;
            err_code_o    <= 2'd0;
            overrun_o     <= 1'b0;
            cmd_id_o      <= '0;
            cmd_len_o     <= '0;
            cmd_payload_o <= '0;
            idx           <= '0;
        end else begin
            frame_err_o <= abort;
            overrun_o   <= strobe && (state == HOLD);
            if (abort) err_code_o <= abort_code;
            if (strobe) begin
                case (state)
                    CMD: begin
                        cmd_id_o      <= rx_data_i;
                        cmd_payload_o <= '0;
                    end
                    LEN: begin
                        if (rx_data_i <= 8'(MAX_PAYLOAD)) cmd_len_o <= rx_data_i[4:0];
                        idx <= '0;
                    end
                    PAYLOAD: begin
                        cmd_payload_o[{idx, 3'b000} +: 8] <= rx_data_i;
                        idx <= idx + 5'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Self-checking bench for uart_cmd_parser: directed frames plus random frames scored against a
// frame-level model (expected command or abort code computed from the byte stream).
module tb_uart_cmd_parser;
    localparam int MAXP  = 16;
    localparam int LIMIT = 1000 * 50;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [7:0]       rx_data = 8'h00;
    logic             rx_int = 1'b0;
    logic             cmd_ready = 1'b0;
    logic             cmd_valid_o;
    logic [7:0]       cmd_id_o;
    logic [4:0]       cmd_len_o;
    logic [8*MAXP-1:0] cmd_payload_o;
    logic             frame_err_o;
    logic [1:0]       err_code_o;
    logic             overrun_o;
    logic             busy_o;

    uart_cmd_parser #(.UART_CLK_MHZ(50), .MAX_PAYLOAD(MAXP), .TIMEOUT_US(1000)) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_data_i    (rx_data),
        .rx_int_i     (rx_int),
        .cmd_valid_o  (cmd_valid_o),
        .cmd_ready_i  (cmd_ready),
        .cmd_id_o     (cmd_id_o),
        .cmd_len_o    (cmd_len_o),
        .cmd_payload_o(cmd_payload_o),
        .frame_err_o  (frame_err_o),
        .err_code_o   (err_code_o),
        .overrun_o    (overrun_o),
        .busy_o       (busy_o)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int n_valid = 0, n_err = 0, n_ovr = 0;

    // Pulse counters sampled away from the active edge.
    always @(negedge clk) begin
        if (cmd_valid_o) n_valid++;
        if (frame_err_o) n_err++;
        if (overrun_o)   n_ovr++;
    end

    logic [7:0]        tx_q[$];
    logic [8*MAXP-1:0] exp_pl, pl_snap;
    logic [7:0]        id, b, chk, sum;
    int                len, kind, err0, ovr0, val0, exp_code;
    bit                exp_ok;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] v);
        int h;
        h = $urandom_range(1, 3);
        @(negedge clk);
        rx_data = v;
        rx_int  = 1'b1;
        repeat (h) @(negedge clk);
        rx_int = 1'b0;
    endtask

    task automatic send_all();
        while (tx_q.size() > 0) send_byte(tx_q.pop_front());
        idle(3);
    endtask

    task automatic handshake();
        @(negedge clk);
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
        #1;
    endtask

    initial begin
        // Reset state
        idle(3);
        check("rst_valid", cmd_valid_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_ferr", frame_err_o, 0);
        check("rst_ovr", overrun_o, 0);
        check("rst_code", err_code_o, 0);
        check("rst_id", cmd_id_o, 0);
        check("rst_len", cmd_len_o, 0);
        check("rst_pl", cmd_payload_o, 0);
        @(negedge clk);
        rst = 1'b0;
        idle(2);

        // Basic frame, consumer always ready: valid for exactly one cycle
        cmd_ready = 1'b1;
        val0 = n_valid;
        tx_q = '{8'hAA, 8'h55, 8'h10, 8'h02, 8'h01, 8'h02, 8'h15};
        send_all();
        check("basic_valid_cycles", n_valid - val0, 1);
        check("basic_id", cmd_id_o, 8'h10);
        check("basic_len", cmd_len_o, 2);
        check("basic_pl", cmd_payload_o, 128'h0201);
        check("basic_busy", busy_o, 0);
        cmd_ready = 1'b0;

        // Wrong checksum byte
        err0 = n_err;
        tx_q = '{8'hAA, 8'h55, 8'h10, 8'h02, 8'h01, 8'h02, 8'h00};
        send_all();
`ifdef UART_CMD_CHKSUM_EN
        check("badchk_err", n_err - err0, 1);
        check("badchk_code", err_code_o, 2);
        check("badchk_valid", cmd_valid_o, 0);
`else
        check("nochk_valid", cmd_valid_o, 1);
        check("nochk_err", n_err - err0, 0);
        handshake();
`endif

        // Oversized length, then a recovered zero-length frame after a doubled AA
        err0 = n_err;
        tx_q = '{8'hAA, 8'h55, 8'h20, 8'h11};
        send_all();
        check("badlen_err", n_err - err0, 1);
        check("badlen_code", err_code_o, 1);
        check("badlen_busy", busy_o, 0);
        tx_q = '{8'hAA, 8'hAA, 8'h55, 8'h30, 8'h00, 8'h30};
        send_all();
        check("len0_valid", cmd_valid_o, 1);
        check("len0_id", cmd_id_o, 8'h30);
        check("len0_len", cmd_len_o, 0);
        check("len0_pl", cmd_payload_o, 0);
        handshake();
        check("len0_busy", busy_o, 0);

        // Held command with an extra byte: overrun, outputs unchanged
        tx_q = '{8'hAA, 8'h55, 8'h10, 8'h02, 8'h01, 8'h02, 8'h15};
        send_all();
        ovr0 = n_ovr;
        send_byte(8'h5C);
        idle(3);
        check("ovr_pulse", n_ovr - ovr0, 1);
        check("ovr_valid", cmd_valid_o, 1);
        check("ovr_id", cmd_id_o, 8'h10);
        check("ovr_pl", cmd_payload_o, 128'h0201);
        handshake();
        check("ovr_busy", busy_o, 0);

        // Byte strobe coinciding with the handshake edge is dropped, not parsed
        tx_q = '{8'hAA, 8'h55, 8'h44, 8'h01, 8'h99, 8'hDE};
        send_all();
        ovr0 = n_ovr;
        @(negedge clk);
        rx_data = 8'hAA;
        rx_int  = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b1;
        @(negedge clk);
        rx_int    = 1'b0;
        cmd_ready = 1'b0;
        idle(3);
        check("hs_ovr_pulse", n_ovr - ovr0, 1);
        check("hs_ovr_busy", busy_o, 0);

        // Random frames against the frame-level model
        for (int f = 0; f < 40; f++) begin
            kind = $urandom_range(0, 3);
            id   = 8'($urandom);
            tx_q.delete();
            if (kind == 3) begin
                for (int n = 0; n < int'($urandom_range(0, 2)); n++) begin
                    b = 8'($urandom);
                    if (b == 8'hAA) b = 8'h00;
                    tx_q.push_back(b);
                end
                tx_q.push_back(8'hAA);
                tx_q.push_back(8'h12);
                tx_q.push_back(8'hAA);
            end
            tx_q.push_back(8'hAA);
            tx_q.push_back(8'h55);
            tx_q.push_back(id);
            if (kind == 1) begin
                len = $urandom_range(MAXP + 1, 255);
                tx_q.push_back(8'(len));
                exp_ok   = 1'b0;
                exp_code = 1;
            end else begin
                len = $urandom_range(0, MAXP);
                tx_q.push_back(8'(len));
                exp_pl = '0;
                sum    = id + 8'(len);
                for (int k = 0; k < len; k++) begin
                    b = 8'($urandom);
                    exp_pl[8*k +: 8] = b;
                    sum = sum + b;
                    tx_q.push_back(b);
                end
                chk      = sum;
                exp_ok   = 1'b1;
                exp_code = 0;
                if (kind == 2) begin
                    chk = sum ^ 8'($urandom_range(1, 255));
`ifdef UART_CMD_CHKSUM_EN
                    exp_ok   = 1'b0;
                    exp_code = 2;
`endif
                end
                tx_q.push_back(chk);
            end
            err0 = n_err;
            val0 = n_valid;
            send_all();
            if (exp_ok) begin
                check("rnd_valid", cmd_valid_o, 1);
                check("rnd_id", cmd_id_o, id);
                check("rnd_len", cmd_len_o, len);
                check("rnd_pl", cmd_payload_o, exp_pl);
                check("rnd_noerr", n_err - err0, 0);
                if (f % 2 == 0) begin
                    ovr0 = n_ovr;
                    send_byte(8'($urandom));
                    idle(3);
                    check("rnd_ovr", n_ovr - ovr0, 1);
                    check("rnd_ovr_pl", cmd_payload_o, exp_pl);
                end
                handshake();
                check("rnd_done_busy", busy_o, 0);
            end else begin
                check("rnd_err", n_err - err0, 1);
                check("rnd_code", err_code_o, exp_code);
                check("rnd_err_busy", busy_o, 0);
                check("rnd_err_novalid", n_valid - val0, 0);
            end
        end

        // Inter-byte timeout
        tx_q = '{8'hAA, 8'h55, 8'h10};
        send_all();
        err0 = n_err;
        idle(LIMIT - 100);
        check("to_still_busy", busy_o, 1);
        check("to_no_err_yet", n_err - err0, 0);
        idle(200);
        check("to_err", n_err - err0, 1);
        check("to_code", err_code_o, 3);
        check("to_busy", busy_o, 0);

        // Reset in the middle of a payload
        tx_q = '{8'hAA, 8'h55, 8'h10, 8'h04, 8'h01, 8'h02};
        send_all();
        check("mid_busy", busy_o, 1);
        err0 = n_err;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mrst_busy", busy_o, 0);
        check("mrst_id", cmd_id_o, 0);
        check("mrst_len", cmd_len_o, 0);
        check("mrst_pl", cmd_payload_o, 0);
        check("mrst_code", err_code_o, 0);
        idle(3);
        check("mrst_noerr", n_err - err0, 0);
        tx_q = '{8'hAA, 8'h55, 8'h21, 8'h01, 8'h7F, 8'hA1};
        send_all();
        check("post_valid", cmd_valid_o, 1);
        check("post_id", cmd_id_o, 8'h21);
        check("post_pl", cmd_payload_o, 128'h7F);
        handshake();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
